snake_move_control: RTL and testbench
=====================================

SNAKE_MOVE_CONTROL -- requirements
Module: snake_move_control

Interface
REQ-001 Parameter STEP_CNT, default 12_500_000, Clk_50mhz cycles per snake step (0.25 s).
REQ-002 Parameter MAX_LEN, default 16, maximum segment count including the head.
REQ-003 Clk_50mhz  input  1  system clock; all state changes on its rising edge.
REQ-004 Rst  input  1  asynchronous, active-high reset.
REQ-005 Start  input  1  level; starts or restarts play from the IDLE or DIE state.
REQ-006 Key_up, Key_down, Key_left, Key_right  input  1 each  direction requests, sampled every cycle.
REQ-007 Body_add_sig  input  1  growth request from the apple generator; a level held for at least one cycle per apple eaten.
REQ-008 Pix_x  input  6  display cell X query.
REQ-009 Pix_y  input  6  display cell Y query.
REQ-010 Head_x  output  6  head cell X, registered.
REQ-011 Head_y  output  6  head cell Y, registered.
REQ-012 Snake_len  output  5  current segment count, registered.
REQ-013 Game_over  output  1  high while in the DIE state.
REQ-014 Body_hit  output  1  registered; high when the (Pix_x, Pix_y) of the previous cycle matches any active segment.

Function
REQ-015 Playfield is X 1..38, Y 1..28; walls are X=0, X=39, Y=0, Y=29.
REQ-016 Segment store holds MAX_LEN (x,y) pairs; segment 0 is the head, and segments 0..Snake_len-1 are active.
REQ-017 FSM states are IDLE, RUN and DIE.
REQ-018 FSM transitions: IDLE->RUN on Start=1; RUN->DIE on collision; DIE->IDLE on Start=1, which reloads the reset body.
REQ-019 Step counter runs only in RUN, counts 0..STEP_CNT-1, asserts a one-cycle step tick at STEP_CNT-1, then wraps to 0; it is cleared when leaving RUN.
REQ-020 Direction register is 2-bit (UP, DOWN, LEFT, RIGHT); key priority is up > down > left > right when several keys are high at once.
REQ-021 A key requesting the exact reverse of the current direction is ignored.
REQ-022 Direction is latched at most once per step, so two keys pressed between ticks cannot produce a reversal.
REQ-023 On a step tick, the next head is the current head plus 1 or minus 1 on one axis according to the direction.
REQ-024 On a step tick, a collision exists when the next head lies on a wall, or equals any active segment 0..Snake_len-2 (with no growth pending) or 0..Snake_len-1 (with growth pending).
REQ-025 Collision on a tick: enter DIE; head, body and length stay frozen at their pre-step values.
REQ-026 No collision on a tick: segment[i] <= segment[i-1] for i = 1..MAX_LEN-1, and segment[0] <= next head.
REQ-027 Growth detection: rising edge of Body_add_sig (registered previous value) sets Grow_pend; a level held over multiple cycles counts once.
REQ-028 On a non-colliding step with Grow_pend set, Snake_len increments (saturating at MAX_LEN) and Grow_pend clears.
REQ-029 An edge in the same cycle as a tick is applied to that tick.
REQ-030 An edge arriving while Grow_pend is already set is absorbed (no second growth).
REQ-031 Grow_pend is cleared on entering IDLE.
REQ-032 Body_hit latency is exactly 1 cycle; Body_hit is 0 in IDLE only if Snake_len=0, which cannot occur, so the body is drawn in every state.
REQ-033 Head_y upper bit is always 0 within the playfield; the full 6 bits are driven.

Reset
REQ-034 Reset values: state IDLE; direction RIGHT; head (20,15); segment 1 (19,15); segment 2 (18,15).
REQ-035 Reset values: Snake_len 3; Game_over 0; Body_hit 0; Grow_pend 0; step counter 0; Body_add_sig history 0.
REQ-036 Segments 3..MAX_LEN-1 reset to (0,0) and are never compared while inactive.
REQ-037 Reset asserted mid-step or in DIE returns all state to the REQ-034/REQ-035 values asynchronously; nothing is held over.
REQ-038 Start=1 in DIE restores the same reset body without asserting Rst.

Verification (STEP_CNT=4 in the bench)
REQ-039 Reset, Start=1, no keys -> after 3 ticks head (23,15), segment 2 (21,15), Snake_len 3.
REQ-040 Heading RIGHT, pulse Key_left then Key_up within one step -> after the next tick head moves up (Y-1), never left.
REQ-041 Body_add_sig high for 10 cycles spanning 2 ticks -> Snake_len goes 3->4 exactly once; the tail stays in place on the growing tick.
REQ-042 Start at (20,15) heading RIGHT, run 18 ticks -> head (38,15), Game_over 0; on the 19th tick Game_over=1 and head stays (38,15).
REQ-043 Length 5, drive the turn sequence UP, LEFT, DOWN -> self-collision on the closing tick gives DIE; Start then gives IDLE with head (20,15) and Snake_len 3.
REQ-044 Drive Pix=(19,15) after reset -> Body_hit=1 on the following cycle; drive Pix=(1,1) -> Body_hit=0.

Source files
------------

// File: rtl/snake_move_control.sv
// Snake movement controller: IDLE/RUN/DIE FSM, step timer, direction latch,
// segment shift register, growth tracking and a one-cycle body-hit query port.
module snake_move_control #(
  parameter int STEP_CNT = 12_500_000,
  parameter int MAX_LEN  = 16
) (
  input  logic       Clk_50mhz,
  input  logic       Rst,
  input  logic       Start,
  input  logic       Key_up,
  input  logic       Key_down,
  input  logic       Key_left,
  input  logic       Key_right,
  input  logic       Body_add_sig,
  input  logic [5:0] Pix_x,
  input  logic [5:0] Pix_y,
  output logic [5:0] Head_x,
  output logic [5:0] Head_y,
  output logic [4:0] Snake_len,
  output logic       Game_over,
  output logic       Body_hit
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DIE} state_t;
  // Direction codes chosen so the reverse of any direction is dir ^ 1.
  localparam logic [1:0] DIR_UP = 2'd0, DIR_DOWN = 2'd1, DIR_LEFT = 2'd2, DIR_RIGHT = 2'd3;
  localparam int         CNT_W    = (STEP_CNT > 1) ? $clog2(STEP_CNT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_CNT - 1);
  localparam logic [4:0] LEN_MAX  = 5'(MAX_LEN);

  state_t                     state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [1:0]                 dir_q, dir_d;
  logic                       lock_q, lock_d;
  logic                       add_prev_q, add_prev_d;
  logic                       grow_pend_q, grow_pend_d;
  logic [4:0]                 len_q, len_d;
  logic                       hit_q, hit_d;
  logic [MAX_LEN-1:0][5:0]    seg_x_q, seg_x_d, seg_y_q, seg_y_d;

  logic       run, tick, reload, collide, wall, self_hit, grow_eff, key_vld, accept;
  logic [1:0] key_dir;
  logic [5:0] nx, ny;
  logic [4:0] lim;

  // Starting body: head at (20,15) with two segments trailing to the left.
  function automatic logic [5:0] init_x(int i);
    return (i < 3) ? 6'(20 - i) : 6'd0;
  endfunction
  function automatic logic [5:0] init_y(int i);
    return (i < 3) ? 6'd15 : 6'd0;
  endfunction

  // State register.
  always_ff @(posedge Clk_50mhz or posedge Rst) begin
    if (Rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (Start)           state_d = ST_RUN;
      ST_RUN:  if (tick && collide) state_d = ST_DIE;
      ST_DIE:  if (Start)           state_d = ST_IDLE;
      default:                      state_d = ST_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    Game_over = (state_q == ST_DIE);
  end

  // Step timing, key arbitration, next-head and collision evaluation.
  always_comb begin
    run      = (state_q == ST_RUN);
    tick     = run && (cnt_q == CNT_LAST);
    reload   = (state_q == ST_DIE) && Start;
    cnt_d    = (run && state_d == ST_RUN) ? (tick ? '0 : cnt_q + 1'b1) : '0;
    key_vld  = Key_up | Key_down | Key_left | Key_right;
    key_dir  = Key_up ? DIR_UP : Key_down ? DIR_DOWN : Key_left ? DIR_LEFT : DIR_RIGHT;
    // On the tick cycle dir_q is the direction being taken, so the reverse
    // check stays against the heading actually moved.
    accept   = run && key_vld && !(lock_q && !tick) && (key_dir != (dir_q ^ 2'd1));
    nx       = seg_x_q[0];
    ny       = seg_y_q[0];
    case (dir_q)
      DIR_UP:   ny = seg_y_q[0] - 6'd1;
      DIR_DOWN: ny = seg_y_q[0] + 6'd1;
      DIR_LEFT: nx = seg_x_q[0] - 6'd1;
      default:  nx = seg_x_q[0] + 6'd1;
    endcase
    wall     = (nx == 6'd0) || (nx == 6'd39) || (ny == 6'd0) || (ny == 6'd29);
    grow_eff = grow_pend_q | (Body_add_sig & ~add_prev_q);
    // Without growth the tail vacates its cell on this step, so it is exempt.
    lim      = grow_eff ? len_q : len_q - 5'd1;
    self_hit = 1'b0;
    for (int i = 0; i < MAX_LEN; i++)
      if (5'(i) < lim && seg_x_q[i] == nx && seg_y_q[i] == ny) self_hit = 1'b1;
    collide  = wall | self_hit;
  end

  // Next values for direction, growth, length, body and hit query.
  always_comb begin
    dir_d       = dir_q;
    lock_d      = lock_q;
    add_prev_d  = Body_add_sig;
    grow_pend_d = grow_eff;
    len_d       = len_q;
    seg_x_d     = seg_x_q;
    seg_y_d     = seg_y_q;
    if (!run)        lock_d = 1'b0;
    else if (accept) lock_d = 1'b1;
    else if (tick)   lock_d = 1'b0;
    if (accept) dir_d = key_dir;
    if (tick && !collide) begin
      for (int i = 1; i < MAX_LEN; i++) begin
        seg_x_d[i] = seg_x_q[i-1];
        seg_y_d[i] = seg_y_q[i-1];
      end
      seg_x_d[0] = nx;
      seg_y_d[0] = ny;
      if (grow_eff) begin
        grow_pend_d = 1'b0;
        if (len_q != LEN_MAX) len_d = len_q + 5'd1;
      end
    end
    if (reload) begin
      dir_d       = DIR_RIGHT;
      grow_pend_d = 1'b0;
      len_d       = 5'd3;
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x_d[i] = init_x(i);
        seg_y_d[i] = init_y(i);
      end
    end
    hit_d = 1'b0;
    for (int i = 0; i < MAX_LEN; i++)
      if (5'(i) < len_q && seg_x_q[i] == Pix_x && seg_y_q[i] == Pix_y) hit_d = 1'b1;
  end

  // Datapath registers.
  always_ff @(posedge Clk_50mhz or posedge Rst) begin
    if (Rst) begin
      cnt_q       <= '0;
      dir_q       <= DIR_RIGHT;
      lock_q      <= 1'b0;
      add_prev_q  <= 1'b0;
      grow_pend_q <= 1'b0;
      len_q       <= 5'd3;
      hit_q       <= 1'b0;
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x_q[i] <= init_x(i);
        seg_y_q[i] <= init_y(i);
      end
    end else begin
      cnt_q       <= cnt_d;
      dir_q       <= dir_d;
      lock_q      <= lock_d;
      add_prev_q  <= add_prev_d;
      grow_pend_q <= grow_pend_d;
      len_q       <= len_d;
      hit_q       <= hit_d;
      seg_x_q     <= seg_x_d;
      seg_y_q     <= seg_y_d;
    end
  end

  assign Head_x    = seg_x_q[0];
  assign Head_y    = seg_y_q[0];
  assign Snake_len = len_q;
  assign Body_hit  = hit_q;

endmodule

// File: tb/tb_snake_move_control.sv
// Directed bench for snake_move_control with a 4-cycle step.
module tb_snake_move_control;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       k_up = 1'b0, k_down = 1'b0, k_left = 1'b0, k_right = 1'b0;
  logic       add = 1'b0;
  logic [5:0] pix_x = '0, pix_y = '0;
  logic [5:0] head_x, head_y;
  logic [4:0] snake_len;
  logic       game_over, body_hit;
  int         checks = 0;
  int         errors = 0;

  snake_move_control #(.STEP_CNT(4), .MAX_LEN(16)) dut (
    .Clk_50mhz(clk), .Rst(rst), .Start(start),
    .Key_up(k_up), .Key_down(k_down), .Key_left(k_left), .Key_right(k_right),
    .Body_add_sig(add), .Pix_x(pix_x), .Pix_y(pix_y),
    .Head_x(head_x), .Head_y(head_y), .Snake_len(snake_len),
    .Game_over(game_over), .Body_hit(body_hit)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; add = 1'b0;
    k_up = 1'b0; k_down = 1'b0; k_left = 1'b0; k_right = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // One-cycle Start pulse; returns one negedge after the Start edge.
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (4 * n) @(negedge clk);
  endtask

  // Drives a cell query and checks Body_hit one cycle later.
  task automatic pix(input string tag, input logic [5:0] x, input logic [5:0] y, input logic exp);
    pix_x = x; pix_y = y;
    @(negedge clk);
    chk(tag, body_hit, exp);
  endtask

  task automatic chk_head(input string tag, input logic [5:0] x, input logic [5:0] y);
    chk({tag, "_x"}, head_x, x);
    chk({tag, "_y"}, head_y, y);
  endtask

  initial begin
    // Reset state and cell query latency
    do_reset();
    chk_head("rst_head", 6'd20, 6'd15);
    chk("rst_len", snake_len, 5'd3);
    chk("rst_go", game_over, 1'b0);
    chk("rst_hit", body_hit, 1'b0);
    pix("hit_seg1", 6'd19, 6'd15, 1'b1);
    pix("hit_none", 6'd1, 6'd1, 1'b0);
    pix("hit_tail", 6'd18, 6'd15, 1'b1);
    pix("hit_past_tail", 6'd17, 6'd15, 1'b0);
    repeat (3) @(negedge clk);
    chk_head("idle_hold", 6'd20, 6'd15);

    // Straight run, three steps
    do_reset();
    pulse_start();
    repeat (3) @(negedge clk);
    chk("pre_tick_x", head_x, 6'd20);
    @(negedge clk);
    chk("tick1_x", head_x, 6'd21);
    step(2);
    chk_head("run3", 6'd23, 6'd15);
    chk("run3_len", snake_len, 5'd3);
    pix("run3_seg2", 6'd21, 6'd15, 1'b1);
    pix("run3_old_tail", 6'd20, 6'd15, 1'b0);

    // Reverse key ignored, then UP taken; then LEFT locks out DOWN
    do_reset();
    pulse_start();
    @(negedge clk); k_left = 1'b1;
    @(negedge clk); k_left = 1'b0; k_up = 1'b1;
    @(negedge clk); k_up = 1'b0;
    @(negedge clk);
    chk_head("turn_up", 6'd20, 6'd14);
    @(negedge clk); k_left = 1'b1;
    @(negedge clk); k_left = 1'b0; k_down = 1'b1;
    @(negedge clk); k_down = 1'b0;
    @(negedge clk);
    chk_head("turn_left_lock", 6'd19, 6'd14);
    step(1);
    chk_head("keep_left", 6'd18, 6'd14);

    // Growth: a 10-cycle level over two ticks grows once, tail stays
    do_reset();
    pulse_start();
    @(negedge clk); add = 1'b1;
    repeat (3) @(negedge clk);
    chk("grow_len", snake_len, 5'd4);
    chk_head("grow_head", 6'd21, 6'd15);
    pix("grow_tail", 6'd18, 6'd15, 1'b1);
    pix("grow_past", 6'd17, 6'd15, 1'b0);
    repeat (2) @(negedge clk);
    chk("grow_once2", snake_len, 5'd4);
    repeat (3) @(negedge clk); add = 1'b0;
    @(negedge clk);
    chk("grow_once3", snake_len, 5'd4);
    chk_head("grow_head3", 6'd23, 6'd15);
    // Asynchronous reset in the middle of a cycle
    #2 rst = 1'b1;
    #1;
    chk_head("async_rst", 6'd20, 6'd15);
    chk("async_rst_len", snake_len, 5'd3);
    @(negedge clk); rst = 1'b0;

    // Wall collision on the right edge, then restart from DIE
    do_reset();
    pulse_start();
    step(18);
    chk_head("wall_last", 6'd38, 6'd15);
    chk("wall_last_go", game_over, 1'b0);
    step(1);
    chk("wall_go", game_over, 1'b1);
    chk_head("wall_frozen", 6'd38, 6'd15);
    step(1);
    chk("die_hold_x", head_x, 6'd38);
    pulse_start();
    chk("die_idle_go", game_over, 1'b0);
    chk_head("die_idle_head", 6'd20, 6'd15);
    repeat (5) @(negedge clk);
    chk("die_idle_stay", head_x, 6'd20);

    // Length 5, UP (with LEFT also held), LEFT, DOWN -> self-collision
    do_reset();
    pulse_start();
    @(negedge clk); add = 1'b1;
    @(negedge clk); add = 1'b0;
    repeat (3) @(negedge clk); add = 1'b1;
    @(negedge clk); add = 1'b0;
    repeat (3) @(negedge clk); k_up = 1'b1; k_left = 1'b1;
    @(negedge clk); k_up = 1'b0; k_left = 1'b0;
    repeat (3) @(negedge clk);
    chk("self_len", snake_len, 5'd5);
    chk_head("self_up", 6'd22, 6'd14);
    k_left = 1'b1;
    @(negedge clk); k_left = 1'b0;
    repeat (2) @(negedge clk);
    chk_head("self_left", 6'd21, 6'd14);
    chk("self_pre_go", game_over, 1'b0);
    @(negedge clk); k_down = 1'b1;
    @(negedge clk); k_down = 1'b0;
    repeat (2) @(negedge clk);
    chk("self_go", game_over, 1'b1);
    chk_head("self_frozen", 6'd21, 6'd14);
    chk("self_len_frozen", snake_len, 5'd5);
    pulse_start();
    chk("self_idle_go", game_over, 1'b0);
    chk_head("self_idle_head", 6'd20, 6'd15);
    chk("self_idle_len", snake_len, 5'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
